e_operand_b_stage: RTL and testbench
====================================

Name: e_operand_b_stage

Overview:
Execute-stage operand-B unit for the pipelined MIPS core, parametrised in data and immediate width. Holds the D→E pipeline register for opcode, register-B value, immediate and rt index, with stall/bubble control. Produces the ALU B operand from that register, with M/W forwarding and full I-type immediate extension. Also produces the forwarded store-data value and an illegal-opcode flag. Sits between decode and the ALU, replacing the fixed-width combinational operand-B mux.

Parameters:
DATA_W, 32, datapath width (≥ 16).
IMM_W, 16, immediate field width (< DATA_W).
REG_AW, 5, register index width.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
d_op  in  6  decoded opcode from D stage.
d_valB  in  DATA_W  register-file rt read value.
d_imm  in  IMM_W  raw immediate field.
d_rt  in  REG_AW  rt register index.
e_stall  in  1  hold the E register.
e_bubble  in  1  load a NOP into the E register.
m_wen  in  1  M stage writes a register.
m_dst  in  REG_AW  M stage destination index.
m_val  in  DATA_W  M stage result.
w_wen  in  1  W stage writes a register.
w_dst  in  REG_AW  W stage destination index.
w_val  in  DATA_W  W stage result.
e_aluB  out  DATA_W  ALU operand B.
e_store_data  out  DATA_W  forwarded rt value for SW.
e_op  out  6  registered opcode, passed on to the ALU and control logic.
e_illegal  out  1  E_op is not in the supported set.

Behaviour:
- Opcode constants: IROP=6'h00, IJ=6'h02, ISLTI=6'h0A, IADDI=6'h08, IANDI=6'h0C, IORI=6'h0D, ILUI=6'h0F, ILW=6'h23, ISW=6'h2B.
- Reset is asynchronous, assertion immediate, no clock needed. E register = NOP: op=IROP, valB=0, imm=0, rt=0.
- Outputs while in reset: e_aluB=0, e_store_data=0, e_op=0, e_illegal=0.
- Release of reset is synchronous to the next rising edge. Reset mid-stall or mid-bubble discards the held instruction.
- E register update, each rising edge, in priority order:
  - e_bubble=1: load NOP. Bubble wins over stall.
  - else e_stall=1: hold all fields.
  - else: load the d_* inputs.
- Latency: one cycle from d_* to e_aluB. All outputs are combinational from the E register and the M/W inputs.
- Forwarded B value fwdB, in priority order:
  - E_rt==0: E_valB. Register $0 is never forwarded.
  - m_wen=1 and m_dst==E_rt: m_val.
  - w_wen=1 and w_dst==E_rt: w_val.
  - otherwise: E_valB.
  - M and W matching the same index simultaneously: M wins.
- e_aluB by opcode:
  - IROP: fwdB.
  - IADDI, ISLTI, ILW, ISW: imm sign-extended to DATA_W.
  - IANDI, IORI: imm zero-extended.
  - ILUI: imm placed in bits [DATA_W-1:DATA_W-IMM_W], zeros below.
  - IJ: 0.
  - any other opcode: 0.
- e_illegal=1 exactly for opcodes outside the list above.
- e_store_data = fwdB for every opcode. Forwarding therefore applies to SW store data.
- No arithmetic overflow is possible. Extension is a pure bit operation.

Decomposition:
- Opcode constants and the NOP encoding go in the shared opcode header already used by decode and the ALU. No new local copies.
- One natural sub-module: imm_extend (op, imm → extended value), parametrised by DATA_W and IMM_W, reused by the branch-target logic.
- Forward mux and E register remain in this module.

Test Plan:
- Reset then release; drive d_op=IROP, d_valB=35, d_rt=3 → next cycle e_aluB=35, e_store_data=35, e_illegal=0.
- d_op=IADDI, d_imm=16'hFFF6 → e_aluB=32'hFFFFFFF6. Same with IORI → e_aluB=32'h0000FFF6. Same with ILUI, d_imm=16'h1234 → e_aluB=32'h12340000.
- E_op=IROP, rt=4, E_valB=1:
  - m_wen=1, m_dst=4, m_val=77 and w_wen=1, w_dst=4, w_val=88 → e_aluB=77.
  - drop m_wen → e_aluB=88.
  - rt=0 with both M and W writing index 0 → e_aluB=1.
- ISW, rt=5, d_imm=8, w_wen=1, w_dst=5, w_val=88 → e_aluB=8, e_store_data=88.
- Load IADDI, imm=3; assert e_stall for 2 cycles with different d_* → e_aluB stays 3. Then assert e_stall and e_bubble together → e_op=IROP, e_aluB=0.
- Load d_op=6'h3F → e_illegal=1, e_aluB=0. Assert rst_n=0 mid-cycle → outputs reach 0 before the next clock edge.
- Parameter sweep with DATA_W=64: repeat the sign-extension and LUI checks against upper-bit expectations.

Source files
------------

// File: rtl/e_operand_b_stage_pkg.sv
// Shared opcode header for decode, ALU and the execute-stage operand units.
// It holds the opcode encodings, the NOP encoding and the legality decode.
package e_operand_b_stage_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] IROP  = 6'h00;
    localparam logic [OP_W-1:0] IJ    = 6'h02;
    localparam logic [OP_W-1:0] IADDI = 6'h08;
    localparam logic [OP_W-1:0] ISLTI = 6'h0A;
    localparam logic [OP_W-1:0] IANDI = 6'h0C;
    localparam logic [OP_W-1:0] IORI  = 6'h0D;
    localparam logic [OP_W-1:0] ILUI  = 6'h0F;
    localparam logic [OP_W-1:0] ILW   = 6'h23;
    localparam logic [OP_W-1:0] ISW   = 6'h2B;

    // A pipeline NOP is an R-type op with all fields cleared.
    localparam logic [OP_W-1:0] NOP_OP = IROP;

    // True for every opcode the core implements.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal_s;
        case (op)
            IROP, IJ, IADDI, ISLTI, IANDI, IORI, ILUI, ILW, ISW: legal_s = 1'b1;
            default:                                            legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/e_operand_b_stage_imm_extend.sv
// Immediate extension for I-type instructions. Pure bit manipulation:
// sign-extend for arithmetic/memory ops, zero-extend for logical ops,
// upper placement for LUI, zero for everything else.
module e_operand_b_stage_imm_extend
    import e_operand_b_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [OP_W-1:0]   op,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] ext
);

    localparam int PAD_W = DATA_W - IMM_W;

    // Select the extension flavour from the opcode.
    always_comb begin
        ext = {DATA_W{1'b0}};
        case (op)
            IADDI, ISLTI, ILW, ISW: ext = {{PAD_W{imm[IMM_W-1]}}, imm};
            IANDI, IORI:            ext = {{PAD_W{1'b0}}, imm};
            ILUI:                   ext = {imm, {PAD_W{1'b0}}};
            default:                ext = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/e_operand_b_stage.sv
// Execute-stage operand-B unit: D->E pipeline register with stall/bubble,
// M/W forwarding of the rt value, ALU operand-B selection, store data and
// illegal-opcode detection. All outputs are combinational from the E
// register and the M/W write-back inputs.
module e_operand_b_stage
    import e_operand_b_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   d_op,
    input  logic [DATA_W-1:0] d_valB,
    input  logic [IMM_W-1:0]  d_imm,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              e_stall,
    input  logic              e_bubble,
    input  logic              m_wen,
    input  logic [REG_AW-1:0] m_dst,
    input  logic [DATA_W-1:0] m_val,
    input  logic              w_wen,
    input  logic [REG_AW-1:0] w_dst,
    input  logic [DATA_W-1:0] w_val,
    output logic [DATA_W-1:0] e_aluB,
    output logic [DATA_W-1:0] e_store_data,
    output logic [OP_W-1:0]   e_op,
    output logic              e_illegal
);

    logic [OP_W-1:0]   e_op_r;
    logic [DATA_W-1:0] e_valb_r;
    logic [IMM_W-1:0]  e_imm_r;
    logic [REG_AW-1:0] e_rt_r;

    logic [DATA_W-1:0] fwd_s;
    logic [DATA_W-1:0] ext_s;

    // E pipeline register: bubble beats stall, stall beats a normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_op_r   <= NOP_OP;
            e_valb_r <= {DATA_W{1'b0}};
            e_imm_r  <= {IMM_W{1'b0}};
            e_rt_r   <= {REG_AW{1'b0}};
        end else if (e_bubble) begin
            e_op_r   <= NOP_OP;
            e_valb_r <= {DATA_W{1'b0}};
            e_imm_r  <= {IMM_W{1'b0}};
            e_rt_r   <= {REG_AW{1'b0}};
        end else if (e_stall) begin
            e_op_r   <= e_op_r;
            e_valb_r <= e_valb_r;
            e_imm_r  <= e_imm_r;
            e_rt_r   <= e_rt_r;
        end else begin
            e_op_r   <= d_op;
            e_valb_r <= d_valB;
            e_imm_r  <= d_imm;
            e_rt_r   <= d_rt;
        end
    end

    // Forward the youngest in-flight write to rt; $0 is never forwarded.
    always_comb begin
        fwd_s = e_valb_r;
        if (e_rt_r == {REG_AW{1'b0}}) begin
            fwd_s = e_valb_r;
        end else if (m_wen && (m_dst == e_rt_r)) begin
            fwd_s = m_val;
        end else if (w_wen && (w_dst == e_rt_r)) begin
            fwd_s = w_val;
        end else begin
            fwd_s = e_valb_r;
        end
    end

    e_operand_b_stage_imm_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_extend (
        .op  (e_op_r),
        .imm (e_imm_r),
        .ext (ext_s)
    );

    // R-type takes the forwarded register; all other ops take the extender,
    // which already yields zero for J and unsupported opcodes.
    always_comb begin
        e_aluB = {DATA_W{1'b0}};
        if (e_op_r == IROP) begin
            e_aluB = fwd_s;
        end else begin
            e_aluB = ext_s;
        end
    end

    // Store data and opcode pass-through plus the legality flag.
    always_comb begin
        e_store_data = fwd_s;
        e_op         = e_op_r;
        e_illegal    = 1'b0;
        if (op_is_legal(e_op_r)) begin
            e_illegal = 1'b0;
        end else begin
            e_illegal = 1'b1;
        end
    end

endmodule

// File: tb/tb_e_operand_b_stage.sv
// Scoreboard bench for e_operand_b_stage: a bench-side model of the E
// register pushes expectations when stimulus is driven; they are popped
// and compared one cycle later. A 64-bit instance covers wide extension.
module tb_e_operand_b_stage;
    import e_operand_b_stage_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] alub;
        logic [31:0] store;
        logic [5:0]  op;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  d_op;
    logic [31:0] d_valB;
    logic [15:0] d_imm;
    logic [4:0]  d_rt;
    logic        e_stall, e_bubble;
    logic        m_wen, w_wen;
    logic [4:0]  m_dst, w_dst;
    logic [31:0] m_val, w_val;
    logic [31:0] e_aluB, e_store_data;
    logic [5:0]  e_op;
    logic        e_illegal;

    logic [63:0] d_valB64, m_val64, w_val64;
    logic [63:0] aluB64, store64;
    logic [5:0]  op64;
    logic        illegal64;

    assign d_valB64 = {32'h0000_0000, d_valB};
    assign m_val64  = {32'h0000_0000, m_val};
    assign w_val64  = {32'h0000_0000, w_val};

    int err_cnt = 0;
    int chk_cnt = 0;
    exp_t sb[$];

    // bench model of the E register
    logic [5:0]  mdl_op;
    logic [31:0] mdl_valb;
    logic [15:0] mdl_imm;
    logic [4:0]  mdl_rt;

    e_operand_b_stage dut (
        .clk(clk), .rst_n(rst_n), .d_op(d_op), .d_valB(d_valB), .d_imm(d_imm),
        .d_rt(d_rt), .e_stall(e_stall), .e_bubble(e_bubble), .m_wen(m_wen),
        .m_dst(m_dst), .m_val(m_val), .w_wen(w_wen), .w_dst(w_dst), .w_val(w_val),
        .e_aluB(e_aluB), .e_store_data(e_store_data), .e_op(e_op), .e_illegal(e_illegal)
    );

    e_operand_b_stage #(.DATA_W(64), .IMM_W(16), .REG_AW(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .d_op(d_op), .d_valB(d_valB64), .d_imm(d_imm),
        .d_rt(d_rt), .e_stall(e_stall), .e_bubble(e_bubble), .m_wen(m_wen),
        .m_dst(m_dst), .m_val(m_val64), .w_wen(w_wen), .w_dst(w_dst), .w_val(w_val64),
        .e_aluB(aluB64), .e_store_data(store64), .e_op(op64), .e_illegal(illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd();
        if (mdl_rt == 5'd0) return mdl_valb;
        if (m_wen && m_dst == mdl_rt) return m_val;
        if (w_wen && w_dst == mdl_rt) return w_val;
        return mdl_valb;
    endfunction

    function automatic logic [31:0] model_alub();
        case (mdl_op)
            6'h00:                      return model_fwd();
            6'h08, 6'h0A, 6'h23, 6'h2B: return {{16{mdl_imm[15]}}, mdl_imm};
            6'h0C, 6'h0D:               return {16'h0000, mdl_imm};
            6'h0F:                      return {mdl_imm, 16'h0000};
            default:                    return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic model_illegal();
        case (mdl_op)
            6'h00, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        mdl_op = 6'h00; mdl_valb = 32'h0; mdl_imm = 16'h0; mdl_rt = 5'd0;
    endtask

    // Drive one cycle of stimulus, push the expectation, then compare after the edge.
    task automatic cycle(input string tag, input logic [5:0] op, input logic [31:0] valb,
                         input logic [15:0] imm, input logic [4:0] rt,
                         input logic stall, input logic bubble);
        exp_t e;
        exp_t g;
        @(negedge clk);
        d_op = op; d_valB = valb; d_imm = imm; d_rt = rt;
        e_stall = stall; e_bubble = bubble;
        if (bubble) model_reset();
        else if (!stall) begin
            mdl_op = op; mdl_valb = valb; mdl_imm = imm; mdl_rt = rt;
        end
        e.tag = tag; e.alub = model_alub(); e.store = model_fwd();
        e.op = mdl_op; e.illegal = model_illegal();
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            g = sb.pop_front();
            check({g.tag, "_aluB"}, {32'h0, e_aluB}, {32'h0, g.alub});
            check({g.tag, "_store"}, {32'h0, e_store_data}, {32'h0, g.store});
            check({g.tag, "_op"}, {58'h0, e_op}, {58'h0, g.op});
            check({g.tag, "_illegal"}, {63'h0, e_illegal}, {63'h0, g.illegal});
        end
    endtask

    logic [5:0] op_tab [10];

    initial begin
        op_tab = '{6'h00, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        rst_n = 1'b0;
        d_op = 6'h0; d_valB = 32'h0; d_imm = 16'h0; d_rt = 5'd0;
        e_stall = 1'b0; e_bubble = 1'b0;
        m_wen = 1'b0; m_dst = 5'd0; m_val = 32'h0;
        w_wen = 1'b0; w_dst = 5'd0; w_val = 32'h0;
        model_reset();
        #2;
        check("rst_aluB", {32'h0, e_aluB}, 64'd0);
        check("rst_store", {32'h0, e_store_data}, 64'd0);
        check("rst_op", {58'h0, e_op}, 64'd0);
        check("rst_illegal", {63'h0, e_illegal}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        cycle("rop", 6'h00, 32'd35, 16'h0, 5'd3, 1'b0, 1'b0);
        check("rop_aluB_const", {32'h0, e_aluB}, 64'd35);

        cycle("addi_neg", 6'h08, 32'h0, 16'hFFF6, 5'd0, 1'b0, 1'b0);
        check("addi_aluB_const", {32'h0, e_aluB}, 64'h0000_0000_FFFF_FFF6);
        check("addi_aluB_w64", aluB64, 64'hFFFF_FFFF_FFFF_FFF6);

        cycle("ori", 6'h0D, 32'h0, 16'hFFF6, 5'd0, 1'b0, 1'b0);
        check("ori_aluB_const", {32'h0, e_aluB}, 64'h0000_0000_0000_FFF6);
        check("ori_aluB_w64", aluB64, 64'h0000_0000_0000_FFF6);

        cycle("lui", 6'h0F, 32'h0, 16'h1234, 5'd0, 1'b0, 1'b0);
        check("lui_aluB_const", {32'h0, e_aluB}, 64'h0000_0000_1234_0000);
        check("lui_aluB_w64", aluB64, 64'h1234_0000_0000_0000);

        m_wen = 1'b1; m_dst = 5'd4; m_val = 32'd77;
        w_wen = 1'b1; w_dst = 5'd4; w_val = 32'd88;
        cycle("fwd_m", 6'h00, 32'd1, 16'h0, 5'd4, 1'b0, 1'b0);
        check("fwd_m_const", {32'h0, e_aluB}, 64'd77);
        m_wen = 1'b0;
        cycle("fwd_w", 6'h00, 32'd9, 16'h0, 5'd9, 1'b1, 1'b0);
        check("fwd_w_const", {32'h0, e_aluB}, 64'd88);
        m_wen = 1'b1; m_dst = 5'd0; w_dst = 5'd0;
        cycle("fwd_r0", 6'h00, 32'd1, 16'h0, 5'd0, 1'b0, 1'b0);
        check("fwd_r0_const", {32'h0, e_aluB}, 64'd1);

        m_wen = 1'b0; w_wen = 1'b1; w_dst = 5'd5; w_val = 32'd88;
        cycle("sw", 6'h2B, 32'd2, 16'd8, 5'd5, 1'b0, 1'b0);
        check("sw_aluB_const", {32'h0, e_aluB}, 64'd8);
        check("sw_store_const", {32'h0, e_store_data}, 64'd88);
        w_wen = 1'b0;

        cycle("hold_ld", 6'h08, 32'd0, 16'd3, 5'd0, 1'b0, 1'b0);
        cycle("hold1", 6'h0D, 32'd5, 16'd99, 5'd6, 1'b1, 1'b0);
        cycle("hold2", 6'h0F, 32'd6, 16'd77, 5'd7, 1'b1, 1'b0);
        check("hold_const", {32'h0, e_aluB}, 64'd3);
        cycle("bubble", 6'h0F, 32'd6, 16'd77, 5'd7, 1'b1, 1'b1);
        check("bubble_op_const", {58'h0, e_op}, 64'd0);
        check("bubble_aluB_const", {32'h0, e_aluB}, 64'd0);

        cycle("illegal", 6'h3F, 32'd12, 16'h7777, 5'd1, 1'b0, 1'b0);
        check("illegal_const", {63'h0, e_illegal}, 64'd1);

        // asynchronous reset in the middle of a cycle
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_aluB", {32'h0, e_aluB}, 64'd0);
        check("arst_store", {32'h0, e_store_data}, 64'd0);
        check("arst_op", {58'h0, e_op}, 64'd0);
        check("arst_illegal", {63'h0, e_illegal}, 64'd0);
        check("arst_aluB_w64", aluB64, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            m_wen = 1'($urandom_range(0, 1)); m_dst = 5'($urandom_range(0, 7));
            m_val = $urandom;
            w_wen = 1'($urandom_range(0, 1)); w_dst = 5'($urandom_range(0, 7));
            w_val = $urandom;
            cycle("rand", op_tab[$urandom_range(0, 9)], $urandom, 16'($urandom),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
